// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accelerator-domain memory arbiter.
package acc_mem_pkg;

   // Which requester owns the read data returning from the SRAM this cycle.
   typedef enum logic [1:0] {
      RSEL_NONE = 2'd0,
      RSEL_CORE = 2'd1,
      RSEL_EXT  = 2'd2
   } rsel_t;

   // Arbiter FSM: plain round-robin, or grant pinned on the external side.
   typedef enum logic {
      ARB_RR   = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   // Encodings of the rr_last flop (side that was accepted most recently).
   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_EXT  = 1'b1;

   // Width of the lock hold-off counter; at least one bit.
   function automatic int cnt_width(input int max_cycles);
      return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
   endfunction

endpackage

// File: rtl/pico_mem_arb_rr.sv
// Two-way round-robin grant. Bit 0 is the core, bit 1 the external side.
module pico_mem_arb_rr
   import acc_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_last,
   input  logic       force_ext,
   output logic [1:0] gnt
);

   // Lock pins the grant on ext even while it idles; otherwise a lone
   // requester wins, and under contention the side not served last wins.
   always_comb begin
      gnt = 2'b00;
      if (force_ext) begin
         gnt[1] = 1'b1;
      end else if (req == 2'b11) begin
         if (rr_last == REQ_EXT) begin
            gnt[0] = 1'b1;
         end else begin
            gnt[1] = 1'b1;
         end
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/pico_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between the picorv32 core
// port and an external (DTU/NoC) requester. Round-robin with an optional
// external lock that is force-released after LOCK_MAX core-wait cycles.
//
// Handshake on both requester ports: a request is presented with x_en_i and
// held (we/addr/wdata stable) while x_stall_o is high. A cycle with x_en_i=1
// and x_stall_o=0 is an acceptance. Reads return x_rdata_o in the cycle
// after acceptance; writes complete at acceptance. x_stall_o is never high
// without x_en_i. The SRAM side mirrors this: sram_en_o with sram_stall_i=0
// is an accepted access.
module pico_mem_arbiter
   import acc_mem_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = 32,
   parameter int LOCK_MAX  = 64
) (
   input  logic                   clk_i,
   input  logic                   resetn_i,
   // core port
   input  logic                   core_en_i,
   input  logic [DATA_SIZE/8-1:0] core_we_i,
   input  logic [ADDR_SIZE-1:0]   core_addr_i,
   input  logic [DATA_SIZE-1:0]   core_wdata_i,
   output logic [DATA_SIZE-1:0]   core_rdata_o,
   output logic                   core_stall_o,
   // external port
   input  logic                   ext_en_i,
   input  logic [DATA_SIZE/8-1:0] ext_we_i,
   input  logic [ADDR_SIZE-1:0]   ext_addr_i,
   input  logic [DATA_SIZE-1:0]   ext_wdata_i,
   input  logic                   ext_lock_i,
   output logic [DATA_SIZE-1:0]   ext_rdata_o,
   output logic                   ext_stall_o,
   // SRAM port
   output logic                   sram_en_o,
   output logic [DATA_SIZE/8-1:0] sram_we_o,
   output logic [ADDR_SIZE-1:0]   sram_addr_o,
   output logic [DATA_SIZE-1:0]   sram_wdata_o,
   input  logic [DATA_SIZE-1:0]   sram_rdata_i,
   input  logic                   sram_stall_i,
   // status
   output logic                   lock_timeout_o,
   // debug visibility of internal state
   output arb_state_t             dbg_state_o,
   output rsel_t                  dbg_rsel_o,
   output logic                   dbg_rr_last_o
);

   localparam int WE_W  = DATA_SIZE / 8;
   localparam int CNT_W = cnt_width(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_t       state_q, state_d;
   logic             rr_last_q, rr_last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   rsel_t            rsel_q, rsel_d;

   logic [1:0]       gnt;
   logic             force_ext;
   logic             acc_core, acc_ext;
   logic             lock_expire;

   pico_mem_arb_rr u_rr (
      .req       ({ext_en_i, core_en_i}),
      .rr_last   (rr_last_q),
      .force_ext (force_ext),
      .gnt       (gnt)
   );

   // Acceptance: requesting, granted, SRAM ready and not in reset.
   assign acc_core = core_en_i & gnt[0] & ~sram_stall_i & resetn_i;
   assign acc_ext  = ext_en_i  & gnt[1] & ~sram_stall_i & resetn_i;

   assign core_stall_o = core_en_i & ~acc_core;
   assign ext_stall_o  = ext_en_i  & ~acc_ext;

   // Lock expiry: the core has now waited LOCK_MAX cycles behind the lock.
   assign lock_expire = (state_q == ARB_LOCK) & core_en_i & ~sram_stall_i &
                        (cnt_q == CNT_LAST);

   // FSM state register.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= ARB_RR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an SRAM stall freezes state, rr_last and the counter.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      cnt_d     = cnt_q;
      if (!sram_stall_i) begin
         case (state_q)
            ARB_RR: begin
               if (acc_core) begin
                  rr_last_d = REQ_CORE;
               end
               if (acc_ext) begin
                  rr_last_d = REQ_EXT;
                  if (ext_lock_i) begin
                     state_d = ARB_LOCK;
                     cnt_d   = '0;
                  end
               end
            end
            ARB_LOCK: begin
               if (lock_expire) begin
                  // Marking ext as last served hands the core the next contention.
                  state_d   = ARB_RR;
                  rr_last_d = REQ_EXT;
                  cnt_d     = '0;
               end else begin
                  if (acc_ext) begin
                     rr_last_d = REQ_EXT;
                  end
                  if (core_en_i) begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
                  if ((acc_ext && !ext_lock_i) || (!ext_en_i && !ext_lock_i)) begin
                     state_d = ARB_RR;
                  end
               end
            end
            default: begin
               state_d = ARB_RR;
            end
         endcase
      end
   end

   // FSM outputs: grant pinning and the force-release pulse.
   always_comb begin
      force_ext      = 1'b0;
      lock_timeout_o = 1'b0;
      if (state_q == ARB_LOCK) begin
         force_ext      = 1'b1;
         lock_timeout_o = lock_expire;
      end
   end

   // Round-robin history and lock hold-off counter.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rr_last_q <= REQ_EXT;
         cnt_q     <= '0;
      end else begin
         rr_last_q <= rr_last_d;
         cnt_q     <= cnt_d;
      end
   end

   // Tag the read that was accepted this cycle so its data can be steered back.
   always_comb begin
      rsel_d = RSEL_NONE;
      if (acc_core && (core_we_i == '0)) begin
         rsel_d = RSEL_CORE;
      end else if (acc_ext && (ext_we_i == '0)) begin
         rsel_d = RSEL_EXT;
      end
   end

   // Read-return owner; reset drops any read still in flight.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rsel_q <= RSEL_NONE;
      end else begin
         rsel_q <= rsel_d;
      end
   end

   // SRAM request mux from the granted side; strobes only with a live access.
   always_comb begin
      sram_en_o    = 1'b0;
      sram_we_o    = '0;
      sram_addr_o  = core_addr_i;
      sram_wdata_o = core_wdata_i;
      if (gnt[1]) begin
         sram_en_o    = ext_en_i & resetn_i;
         sram_addr_o  = ext_addr_i;
         sram_wdata_o = ext_wdata_i;
         sram_we_o    = sram_en_o ? ext_we_i : {WE_W{1'b0}};
      end else if (gnt[0]) begin
         sram_en_o    = core_en_i & resetn_i;
         sram_we_o    = sram_en_o ? core_we_i : {WE_W{1'b0}};
      end
   end

   assign core_rdata_o = (rsel_q == RSEL_CORE) ? sram_rdata_i : '0;
   assign ext_rdata_o  = (rsel_q == RSEL_EXT)  ? sram_rdata_i : '0;

   assign dbg_state_o   = state_q;
   assign dbg_rsel_o    = rsel_q;
   assign dbg_rr_last_o = rr_last_q;

endmodule

// File: tb/tb_pico_mem_arbiter.sv
// Bench for pico_mem_arbiter: SRAM model, per-port drivers, read-return
// scoreboard, plus a LOCK_MAX=8 instance for the lock force-release.
module tb_pico_mem_arbiter;
   import acc_mem_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   logic resetn_i;

   // ---------------- main DUT signals ----------------
   logic        core_en_i, ext_en_i, ext_lock_i, sram_stall_i;
   logic [3:0]  core_we_i, ext_we_i;
   logic [31:0] core_addr_i, core_wdata_i, ext_addr_i, ext_wdata_i;
   logic [31:0] core_rdata_o, ext_rdata_o, sram_addr_o, sram_wdata_o;
   logic [31:0] sram_rdata_i;
   logic        core_stall_o, ext_stall_o, sram_en_o, lock_timeout_o;
   logic [3:0]  sram_we_o;
   arb_state_t  dbg_state_o;
   rsel_t       dbg_rsel_o;
   logic        dbg_rr_last_o;

   pico_mem_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(32), .LOCK_MAX(64)) u_dut (
      .clk_i(clk_i), .resetn_i(resetn_i),
      .core_en_i(core_en_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
      .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
      .ext_en_i(ext_en_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
      .ext_wdata_i(ext_wdata_i), .ext_lock_i(ext_lock_i), .ext_rdata_o(ext_rdata_o),
      .ext_stall_o(ext_stall_o),
      .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
      .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i), .sram_stall_i(sram_stall_i),
      .lock_timeout_o(lock_timeout_o),
      .dbg_state_o(dbg_state_o), .dbg_rsel_o(dbg_rsel_o), .dbg_rr_last_o(dbg_rr_last_o)
   );

   // ---------------- LOCK_MAX=8 DUT signals ----------------
   logic        t_core_en, t_ext_en, t_ext_lock;
   logic [31:0] t_core_rdata, t_ext_rdata, t_sram_addr, t_sram_wdata;
   logic        t_core_stall, t_ext_stall, t_sram_en, t_timeout, t_rr_last;
   logic [3:0]  t_sram_we;
   arb_state_t  t_state;
   rsel_t       t_rsel;

   pico_mem_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(32), .LOCK_MAX(8)) u_dut8 (
      .clk_i(clk_i), .resetn_i(resetn_i),
      .core_en_i(t_core_en), .core_we_i(4'h0), .core_addr_i(32'h0),
      .core_wdata_i(32'h0), .core_rdata_o(t_core_rdata), .core_stall_o(t_core_stall),
      .ext_en_i(t_ext_en), .ext_we_i(4'hF), .ext_addr_i(32'h40),
      .ext_wdata_i(32'h1234_5678), .ext_lock_i(t_ext_lock), .ext_rdata_o(t_ext_rdata),
      .ext_stall_o(t_ext_stall),
      .sram_en_o(t_sram_en), .sram_we_o(t_sram_we), .sram_addr_o(t_sram_addr),
      .sram_wdata_o(t_sram_wdata), .sram_rdata_i(32'h0), .sram_stall_i(1'b0),
      .lock_timeout_o(t_timeout),
      .dbg_state_o(t_state), .dbg_rsel_o(t_rsel), .dbg_rr_last_o(t_rr_last)
   );

   // ---------------- SRAM model (1-cycle read latency) ----------------
   // Preload: word i holds 0x1000_0000+i, word 0x40 (addr 0x100) holds 0xDEADBEEF.
   logic [31:0] mem [0:255];
   always @(posedge clk_i) begin
      if (!resetn_i) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
         mem[8'h40]   <= 32'hDEAD_BEEF;
         sram_rdata_i <= 32'h0;
      end else if (sram_en_o && !sram_stall_i) begin
         if (sram_we_o == 4'h0) begin
            sram_rdata_i <= mem[sram_addr_o[9:2]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (sram_we_o[b]) mem[sram_addr_o[9:2]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
         end
      end
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [31:0] core_exp_q[$];
   logic [31:0] ext_exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one cycle after each observed read acceptance, pop and compare;
   // in every other cycle the port's rdata must be zero.
   initial begin
      logic pend_core, pend_ext;
      logic [31:0] e;
      pend_core = 1'b0;
      pend_ext  = 1'b0;
      forever begin
         @(negedge clk_i);
         if (pend_core) begin
            if (core_exp_q.size() == 0) begin
               check("core_rdata_unexpected", 32'h1, 32'h0);
            end else begin
               e = core_exp_q.pop_front();
               check("core_rdata", core_rdata_o, e);
            end
         end else begin
            check("core_rdata_idle", core_rdata_o, 32'h0);
         end
         if (pend_ext) begin
            if (ext_exp_q.size() == 0) begin
               check("ext_rdata_unexpected", 32'h1, 32'h0);
            end else begin
               e = ext_exp_q.pop_front();
               check("ext_rdata", ext_rdata_o, e);
            end
         end else begin
            check("ext_rdata_idle", ext_rdata_o, 32'h0);
         end
         pend_core = resetn_i && core_en_i && !core_stall_o && (core_we_i == 4'h0);
         pend_ext  = resetn_i && ext_en_i  && !ext_stall_o  && (ext_we_i  == 4'h0);
      end
   end

   // ---------------- drivers ----------------
   // Present a request, hold it until accepted, report stalled cycles.
   task automatic core_req(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp, output int waits);
      core_en_i = 1'b1; core_we_i = we; core_addr_i = addr; core_wdata_i = wd;
      waits = 0;
      @(negedge clk_i);
      while (core_stall_o && waits < 50) begin
         waits++;
         @(negedge clk_i);
      end
      if (core_stall_o) check("core_accept_bound", 32'h1, 32'h0);
      else if (we == 4'h0) core_exp_q.push_back(exp);
      @(posedge clk_i);
      #1;
      core_en_i = 1'b0; core_we_i = 4'h0;
   endtask

   task automatic ext_req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic lock, input logic [31:0] exp, output int waits);
      ext_en_i = 1'b1; ext_we_i = we; ext_addr_i = addr; ext_wdata_i = wd; ext_lock_i = lock;
      waits = 0;
      @(negedge clk_i);
      while (ext_stall_o && waits < 50) begin
         waits++;
         @(negedge clk_i);
      end
      if (ext_stall_o) check("ext_accept_bound", 32'h1, 32'h0);
      else if (we == 4'h0) ext_exp_q.push_back(exp);
      @(posedge clk_i);
      #1;
      ext_en_i = 1'b0; ext_we_i = 4'h0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int w0, w1, w2, x0, x1, x2;
      resetn_i = 1'b0;
      core_en_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0;
      ext_en_i = 0; ext_we_i = 0; ext_addr_i = 0; ext_wdata_i = 0; ext_lock_i = 0;
      sram_stall_i = 0;
      t_core_en = 0; t_ext_en = 0; t_ext_lock = 0;
      repeat (3) @(posedge clk_i);

      // reset state
      @(negedge clk_i);
      check("rst_sram_en", {31'b0, sram_en_o}, 32'h0);
      check("rst_timeout", {31'b0, lock_timeout_o}, 32'h0);
      check("rst_state", {31'b0, dbg_state_o}, {31'b0, ARB_RR});
      check("rst_rsel", {30'b0, dbg_rsel_o}, {30'b0, RSEL_NONE});
      check("rst_rr_last", {31'b0, dbg_rr_last_o}, {31'b0, REQ_EXT});
      @(posedge clk_i);
      #1 resetn_i = 1'b1;

      // contention from reset: core first, then strict alternation
      fork
         begin
            core_req(4'h0, 32'h04, 32'h0, 32'h1000_0001, w0);
            core_req(4'h0, 32'h08, 32'h0, 32'h1000_0002, w1);
            core_req(4'h0, 32'h0C, 32'h0, 32'h1000_0003, w2);
         end
         begin
            ext_req(4'h0, 32'h10, 32'h0, 1'b0, 32'h1000_0004, x0);
            ext_req(4'h0, 32'h14, 32'h0, 1'b0, 32'h1000_0005, x1);
            ext_req(4'h0, 32'h18, 32'h0, 1'b0, 32'h1000_0006, x2);
         end
      join
      check("rr_core_wait0", w0, 0);
      check("rr_core_wait1", w1, 1);
      check("rr_core_wait2", w2, 1);
      check("rr_ext_wait0", x0, 1);
      check("rr_ext_wait1", x1, 1);
      check("rr_ext_wait2", x2, 1);

      // core-only read of 0x100
      core_req(4'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, w0);
      check("solo_core_wait", w0, 0);

      // ext locked write, core held off while ext idles locked
      ext_req(4'hF, 32'h80, 32'hCAFE_0123, 1'b1, 32'h0, x0);
      check("lock_ext_wait", x0, 0);
      core_en_i = 1'b1; core_we_i = 4'h0; core_addr_i = 32'h80;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         check("lock_core_stall", {31'b0, core_stall_o}, 32'h1);
      end
      check("lock_state", {31'b0, dbg_state_o}, {31'b0, ARB_LOCK});
      @(posedge clk_i);
      #1 ext_lock_i = 1'b0;
      core_req(4'h0, 32'h80, 32'h0, 32'hCAFE_0123, w0);
      check("unlock_core_wait", w0, 1);

      // SRAM stall: three frozen cycles, then ext (not served last) wins
      sram_stall_i = 1'b1;
      fork
         core_req(4'h0, 32'h1C, 32'h0, 32'h1000_0007, w0);
         ext_req(4'h0, 32'h20, 32'h0, 1'b0, 32'h1000_0008, x0);
         begin
            for (int k = 0; k < 3; k++) begin
               @(negedge clk_i);
               check("sstall_core", {31'b0, core_stall_o}, 32'h1);
               check("sstall_ext", {31'b0, ext_stall_o}, 32'h1);
               check("sstall_state", {31'b0, dbg_state_o}, {31'b0, ARB_RR});
               check("sstall_rr_last", {31'b0, dbg_rr_last_o}, {31'b0, REQ_CORE});
            end
            @(posedge clk_i);
            #1 sram_stall_i = 1'b0;
         end
      join
      check("sstall_ext_wait", x0, 3);
      check("sstall_core_wait", w0, 4);

      // reset right after a core read accept discards the return
      core_req(4'h0, 32'h24, 32'h0, 32'h0, w0);
      check("rstread_wait", w0, 0);
      resetn_i = 1'b0;
      @(negedge clk_i);
      check("rstread_rsel", {30'b0, dbg_rsel_o}, {30'b0, RSEL_NONE});
      check("rstread_state", {31'b0, dbg_state_o}, {31'b0, ARB_RR});
      repeat (2) @(posedge clk_i);
      #1 resetn_i = 1'b1;
      fork
         core_req(4'h0, 32'h28, 32'h0, 32'h1000_000A, w0);
         ext_req(4'h0, 32'h2C, 32'h0, 1'b0, 32'h1000_000B, x0);
      join
      check("postrst_core_wait", w0, 0);
      check("postrst_ext_wait", x0, 1);

      // LOCK_MAX=8 instance: force-release on the 8th core-wait cycle
      t_ext_lock = 1'b1;
      t_ext_en   = 1'b1;
      @(negedge clk_i);
      check("to_ext_accept", {31'b0, t_ext_stall}, 32'h0);
      @(posedge clk_i);
      #1;
      t_ext_en  = 1'b0;
      t_core_en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         check("to_pulse", {31'b0, t_timeout}, (k == 8) ? 32'h1 : 32'h0);
         check("to_core_stall", {31'b0, t_core_stall}, 32'h1);
      end
      @(posedge clk_i);
      #1 t_ext_en = 1'b1;
      @(negedge clk_i);
      check("to_core_wins", {31'b0, t_core_stall}, 32'h0);
      check("to_ext_loses", {31'b0, t_ext_stall}, 32'h1);
      check("to_state", {31'b0, t_state}, {31'b0, ARB_RR});
      @(posedge clk_i);
      #1;
      t_core_en = 1'b0; t_ext_en = 1'b0; t_ext_lock = 1'b0;

      repeat (3) @(posedge clk_i);
      check("final_core_q_empty", core_exp_q.size(), 0);
      check("final_ext_q_empty", ext_exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
